// File: rtl/vga_timing_gen.sv
// 640x480 @ 60 Hz VGA raster timing generator for the Pong top level.
// Produces the pixel-rate tick, raster counters, registered syncs/video_on and a per-frame pulse.
module vga_timing_gen #(
    parameter int TICK_DIV  = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] divider;
    logic             advance;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    // The pixel advances on the same edge that raises p_tick, so the tick
    // cycle already shows the new coordinates and their decoded outputs.
    assign advance = (divider == DIV_W'(TICK_DIV - 1));

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divider <= '0;
            p_tick  <= 1'b0;
        end else begin
            divider <= advance ? '0 : divider + DIV_W'(1);
            p_tick  <= advance;
        end
    end

    // NOTE: next-state values get defaults up front so no path leaves them
    // unassigned, which would otherwise infer latches.
    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (advance) begin
            if (pixel_x == 10'(H_TOTAL - 1)) begin
                x_next = '0;
                y_next = (pixel_y == 10'(V_TOTAL - 1)) ? '0 : pixel_y + 10'd1;
            end else begin
                x_next = pixel_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_x    <= '0;
            pixel_y    <= '0;
            video_on   <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= advance && (x_next == 10'd0) && (y_next == 10'(V_DISPLAY));
            if (advance) begin
                pixel_x  <= x_next;
                pixel_y  <= y_next;
                video_on <= (x_next < 10'(H_DISPLAY)) && (y_next < 10'(V_DISPLAY));
                hsync    <= !((x_next >= 10'(HS_START)) && (x_next <= 10'(HS_END)));
                vsync    <= !((y_next >= 10'(VS_START)) && (y_next <= 10'(VS_END)));
            end
        end
    end

endmodule
